// File: rtl/midi_parser.sv
// -----------------------------------------------------------------------------
// midi_parser
//
// Decodes MIDI channel voice messages from the byte stream delivered by the
// UART receiver and drives a monophonic note/gate interface for the synth
// voice (oscillator/envelope stage).
//
// Parsing handles running status, interleaved real-time bytes and messages
// addressed to other channels. Only note-on, note-off and All Notes Off
// (controller 123) change the outputs. Every other message is parsed for
// length and then discarded.
//
// Parameters
//   CHANNEL      MIDI channel accepted (0..15).
//   OMNI         1: accept every channel and ignore CHANNEL.
//
// Ports
//   clk_i        system clock, single domain
//   rst_i        synchronous, active-high reset
//   byte_i       received byte, qualified by byteValid_i
//   byteValid_i  one-cycle strobe per received byte (may be back-to-back)
//   note_o       current note number
//   velocity_o   velocity of the last accepted note-on
//   gate_o       high while the current note is held
//   noteOn_o     one-cycle strobe when a note-on is accepted
//   noteOff_o    one-cycle strobe when the gate is released
// -----------------------------------------------------------------------------
module midi_parser #(
  parameter int unsigned CHANNEL = 0,
  parameter bit          OMNI    = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] byte_i,
  input  logic       byteValid_i,
  output logic [6:0] note_o,
  output logic [6:0] velocity_o,
  output logic       gate_o,
  output logic       noteOn_o,
  output logic       noteOff_o
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE,  // no running status, or waiting for a new status byte
    S_D1,    // awaiting first data byte
    S_D2     // awaiting second data byte
  } parserState_e;

  typedef enum logic [1:0] {
    BC_REALTIME,  // 0xF8-0xFF
    BC_SYSTEM,    // 0xF0-0xF7
    BC_STATUS,    // 0x80-0xEF
    BC_DATA       // 0x00-0x7F
  } byteClass_e;

  localparam logic [3:0] ChannelSel    = 4'(CHANNEL);
  localparam logic [3:0] MsgNoteOff    = 4'h8;
  localparam logic [3:0] MsgNoteOn     = 4'h9;
  localparam logic [3:0] MsgControl    = 4'hB;
  localparam logic [3:0] MsgProgram    = 4'hC;
  localparam logic [3:0] MsgPressure   = 4'hD;
  localparam logic [6:0] CtlAllNotesOff = 7'd123;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic byteClass_e classify(input logic [7:0] b);
    if (b >= 8'hF8) begin
      return BC_REALTIME;
    end else if (b >= 8'hF0) begin
      return BC_SYSTEM;
    end else if (b[7]) begin
      return BC_STATUS;
    end else begin
      return BC_DATA;
    end
  endfunction

  // Program change and channel pressure carry one data byte; every other
  // channel voice message carries two.
  function automatic logic isTwoByte(input logic [3:0] kind);
    return !((kind == MsgProgram) || (kind == MsgPressure));
  endfunction

  // ---------------------------------------------------------------------------
  // Parser state
  // ---------------------------------------------------------------------------
  parserState_e state, stateNext;
  logic [7:0]   status, statusNext;  // running status, 0 = none
  logic [6:0]   d1, d1Next;          // first data byte of the current message
  logic         msgDone;             // last data byte of a 2-byte message seen

  byteClass_e   byteClass;
  logic         statusValid;
  logic [3:0]   msgKind;
  logic         chanMatch;

  assign byteClass   = classify(byte_i);
  assign statusValid = status[7];
  assign msgKind     = status[7:4];
  assign chanMatch   = OMNI || (status[3:0] == ChannelSel);

  // Output next-values
  logic [6:0] noteNext, velocityNext;
  logic       gateNext, noteOnNext, noteOffNext;

  // ---------------------------------------------------------------------------
  // Process 1: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of the others; blocking here would create order-dependent
  // shift-through between registers in the same block.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      status <= '0;
      // NOTE: d1 is plain data and would work without reset, but a mid-message
      // reset must discard partial data, so clearing it keeps the parser fully
      // defined after reset at the cost of one reset mux per bit.
      d1     <= '0;
    end else begin
      state  <= stateNext;
      status <= statusNext;
      d1     <= d1Next;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default first; any path that
    // left one unassigned would infer a latch.
    stateNext  = state;
    statusNext = status;
    d1Next     = d1;
    msgDone    = 1'b0;

    if (byteValid_i) begin
      unique case (byteClass)
        // Real-time bytes may appear anywhere, even inside a message, and
        // must leave the parser untouched.
        BC_REALTIME: ;

        BC_SYSTEM: begin
          statusNext = '0;
          stateNext  = S_IDLE;
        end

        BC_STATUS: begin
          statusNext = byte_i;
          stateNext  = S_D1;
        end

        BC_DATA: begin
          unique case (state)
            // A data byte in S_IDLE is the first byte of a running-status
            // message when a status is still held; otherwise it is dropped.
            S_IDLE, S_D1: begin
              if (statusValid) begin
                d1Next    = byte_i[6:0];
                // One-byte messages complete here and need no action;
                // staying in S_D1 keeps running status alive.
                stateNext = isTwoByte(msgKind) ? S_D2 : S_D1;
              end
            end
            S_D2: begin
              msgDone   = 1'b1;
              stateNext = S_D1;
            end
            default: stateNext = S_IDLE;
          endcase
        end

        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Process 3: output logic
  // ---------------------------------------------------------------------------
  // On message completion, byte_i holds d2 and d1 holds the first data byte.
  logic [6:0] d2;
  logic       execute;
  logic       releaseHit;  // note-off that matches the held note

  assign d2         = byte_i[6:0];
  assign execute    = msgDone && chanMatch;
  assign releaseHit = gate_o && (d1 == note_o);

  always_comb begin
    noteNext     = note_o;
    velocityNext = velocity_o;
    gateNext     = gate_o;
    noteOnNext   = 1'b0;
    noteOffNext  = 1'b0;

    if (execute) begin
      unique case (msgKind)
        MsgNoteOn: begin
          if (d2 != 7'd0) begin
            // Last-note priority: a new note-on simply takes over the voice,
            // so no release is signalled for the note it replaces.
            noteNext     = d1;
            velocityNext = d2;
            gateNext     = 1'b1;
            noteOnNext   = 1'b1;
          end else if (releaseHit) begin
            // Velocity-0 note-on is the running-status form of note-off.
            gateNext    = 1'b0;
            noteOffNext = 1'b1;
          end
        end

        MsgNoteOff: begin
          if (releaseHit) begin
            gateNext    = 1'b0;
            noteOffNext = 1'b1;
          end
        end

        MsgControl: begin
          // All Notes Off releases whatever is held; note and velocity are
          // kept so the envelope release still has its pitch.
          if ((d1 == CtlAllNotesOff) && gate_o) begin
            gateNext    = 1'b0;
            noteOffNext = 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

  // Output register: outputs appear one cycle after the final data strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      note_o     <= '0;
      velocity_o <= '0;
      gate_o     <= 1'b0;
      noteOn_o   <= 1'b0;
      noteOff_o  <= 1'b0;
    end else begin
      note_o     <= noteNext;
      velocity_o <= velocityNext;
      gate_o     <= gateNext;
      noteOn_o   <= noteOnNext;
      noteOff_o  <= noteOffNext;
    end
  end

endmodule

// File: tb/tb_midi_parser.sv
// -----------------------------------------------------------------------------
// tb_midi_parser
//
// Directed bench for midi_parser with CHANNEL=0, OMNI=0. Bytes are driven on
// the falling edge and held for exactly one cycle, so consecutive sendByte
// calls produce back-to-back strobes. Outputs are read on the falling edge,
// half a cycle after the rising edge that registered them. Strobe pulses are
// also counted on every rising edge so multi-message sequences can be checked.
// -----------------------------------------------------------------------------
module tb_midi_parser;

  logic       clk_i;
  logic       rst_i;
  logic [7:0] byte_i;
  logic       byteValid_i;
  logic [6:0] note_o;
  logic [6:0] velocity_o;
  logic       gate_o;
  logic       noteOn_o;
  logic       noteOff_o;

  int checks   = 0;
  int failures = 0;

  int onCount   = 0;
  int offCount  = 0;
  int bothCount = 0;
  int onBase;
  int offBase;

  midi_parser #(
    .CHANNEL (0),
    .OMNI    (1'b0)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .byte_i      (byte_i),
    .byteValid_i (byteValid_i),
    .note_o      (note_o),
    .velocity_o  (velocity_o),
    .gate_o      (gate_o),
    .noteOn_o    (noteOn_o),
    .noteOff_o   (noteOff_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Pulse monitor: sees the value registered on the previous rising edge.
  always @(posedge clk_i) begin
    if (noteOn_o)              onCount++;
    if (noteOff_o)             offCount++;
    if (noteOn_o && noteOff_o) bothCount++;
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Call on a falling edge; returns on the next falling edge, by which time
  // the rising edge that sampled the byte has registered its outputs.
  task automatic sendByte(input logic [7:0] b);
    byte_i      = b;
    byteValid_i = 1'b1;
    @(negedge clk_i);
    byteValid_i = 1'b0;
    byte_i      = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    rst_i       = 1'b1;
    byte_i      = 8'h00;
    byteValid_i = 1'b0;
    idle(2);
    rst_i = 1'b0;

    // ---- reset state ----
    check("rst_note",     32'(note_o),     32'h0);
    check("rst_velocity", 32'(velocity_o), 32'h0);
    check("rst_gate",     32'(gate_o),     32'h0);
    check("rst_strobes",  32'({noteOn_o, noteOff_o}), 32'h0);

    // ---- basic note-on: 90 3C 64 ----
    sendByte(8'h90); sendByte(8'h3C); sendByte(8'h64);
    check("on1_pulse",    32'(noteOn_o),   32'h1);
    check("on1_offpulse", 32'(noteOff_o),  32'h0);
    check("on1_note",     32'(note_o),     32'h3C);
    check("on1_velocity", 32'(velocity_o), 32'h64);
    check("on1_gate",     32'(gate_o),     32'h1);
    idle(1);
    check("on1_pulse_end", 32'(noteOn_o),  32'h0);

    // ---- running status: 90 3C 64 40 50, back-to-back ----
    onBase  = onCount;
    offBase = offCount;
    sendByte(8'h90); sendByte(8'h3C); sendByte(8'h64);
    sendByte(8'h40); sendByte(8'h50);
    idle(1);
    check("rs_on_pulses",  32'(onCount - onBase),   32'd2);
    check("rs_no_release", 32'(offCount - offBase), 32'd0);
    check("rs_note",       32'(note_o),     32'h40);
    check("rs_velocity",   32'(velocity_o), 32'h50);
    check("rs_gate",       32'(gate_o),     32'h1);

    // ---- note-off for a note that is not held: 80 3C 00 ----
    offBase = offCount;
    sendByte(8'h80); sendByte(8'h3C); sendByte(8'h00);
    idle(1);
    check("off_miss_pulses", 32'(offCount - offBase), 32'd0);
    check("off_miss_gate",   32'(gate_o), 32'h1);
    check("off_miss_note",   32'(note_o), 32'h40);

    // ---- velocity-0 note-on releases the held note: 90 40 00 ----
    sendByte(8'h90); sendByte(8'h40); sendByte(8'h00);
    check("off_hit_pulse",    32'(noteOff_o),  32'h1);
    check("off_hit_onpulse",  32'(noteOn_o),   32'h0);
    check("off_hit_gate",     32'(gate_o),     32'h0);
    check("off_hit_note",     32'(note_o),     32'h40);
    check("off_hit_velocity", 32'(velocity_o), 32'h50);
    idle(1);
    check("off_hit_pulse_end", 32'(noteOff_o), 32'h0);

    // ---- real-time bytes interleaved: 90 F8 3C FE 64 ----
    sendByte(8'h90); sendByte(8'hF8); sendByte(8'h3C);
    sendByte(8'hFE); sendByte(8'h64);
    check("rt_pulse",    32'(noteOn_o),   32'h1);
    check("rt_note",     32'(note_o),     32'h3C);
    check("rt_velocity", 32'(velocity_o), 32'h64);
    check("rt_gate",     32'(gate_o),     32'h1);
    idle(1);

    // ---- system byte clears running status: F0 3C 64 ----
    onBase  = onCount;
    offBase = offCount;
    sendByte(8'hF0); sendByte(8'h3C); sendByte(8'h64);
    idle(1);
    check("sys_pulses", 32'(onCount - onBase + offCount - offBase), 32'd0);
    check("sys_note",   32'(note_o),     32'h3C);
    check("sys_vel",    32'(velocity_o), 32'h64);
    check("sys_gate",   32'(gate_o),     32'h1);

    // ---- other channel: 91 45 70 and 81 3C 00 ----
    onBase  = onCount;
    offBase = offCount;
    sendByte(8'h91); sendByte(8'h45); sendByte(8'h70);
    sendByte(8'h81); sendByte(8'h3C); sendByte(8'h00);
    idle(1);
    check("chan_pulses", 32'(onCount - onBase + offCount - offBase), 32'd0);
    check("chan_note",   32'(note_o),     32'h3C);
    check("chan_vel",    32'(velocity_o), 32'h64);
    check("chan_gate",   32'(gate_o),     32'h1);

    // ---- one-byte messages with running status: C0 05 45 70 ----
    onBase  = onCount;
    offBase = offCount;
    sendByte(8'hC0); sendByte(8'h05); sendByte(8'h45); sendByte(8'h70);
    idle(1);
    check("pc_pulses", 32'(onCount - onBase + offCount - offBase), 32'd0);
    check("pc_note",   32'(note_o),     32'h3C);
    check("pc_vel",    32'(velocity_o), 32'h64);
    check("pc_gate",   32'(gate_o),     32'h1);

    // ---- All Notes Off while held: B0 7B 00 ----
    sendByte(8'hB0); sendByte(8'h7B); sendByte(8'h00);
    check("ano_pulse",    32'(noteOff_o),  32'h1);
    check("ano_gate",     32'(gate_o),     32'h0);
    check("ano_note",     32'(note_o),     32'h3C);
    check("ano_velocity", 32'(velocity_o), 32'h64);
    idle(1);

    // ---- All Notes Off again (running status) with gate low: 7B 00 ----
    offBase = offCount;
    sendByte(8'h7B); sendByte(8'h00);
    idle(1);
    check("ano_idle_pulses", 32'(offCount - offBase), 32'd0);

    // ---- reset mid-message, reset wins over a simultaneous strobe ----
    onBase = onCount;
    sendByte(8'h90); sendByte(8'h3C);
    rst_i       = 1'b1;
    byte_i      = 8'h64;
    byteValid_i = 1'b1;
    @(negedge clk_i);
    rst_i       = 1'b0;
    byteValid_i = 1'b0;
    byte_i      = 8'h00;
    sendByte(8'h64);
    idle(1);
    check("rstmid_pulses",   32'(onCount - onBase), 32'd0);
    check("rstmid_note",     32'(note_o),     32'h0);
    check("rstmid_velocity", 32'(velocity_o), 32'h0);
    check("rstmid_gate",     32'(gate_o),     32'h0);

    // ---- parser resumes normally after reset ----
    sendByte(8'h90); sendByte(8'h30); sendByte(8'h7F);
    check("post_rst_pulse", 32'(noteOn_o), 32'h1);
    check("post_rst_note",  32'(note_o),   32'h30);
    check("post_rst_vel",   32'(velocity_o), 32'h7F);
    idle(2);

    check("never_both_strobes", 32'(bothCount), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
